// File: rtl/audio_demux4.sv
// 1:4 sample demultiplexer with valid/ready handshakes.
// Zero samples are sent to the old channel on a select change.
module audio_demux4 #(
  parameter int width    = 16,
  parameter int MUTE_LEN = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [width-1:0] din,
  input  logic [1:0]       s,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [width-1:0] dout,
  output logic [3:0]       dout_valid,
  input  logic [3:0]       dout_ready,
  output logic [1:0]       active_sel,
  output logic             switching
);

  localparam int CW = (MUTE_LEN > 0) ? $clog2(MUTE_LEN + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    MUTE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_cur_sel, w_cur_sel_nxt;
  logic [1:0]       r_pend, w_pend_nxt;
  logic [width-1:0] r_dout, w_dout_nxt;
  logic [width-1:0] r_held, w_held_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  logic             w_out_hs;
  logic             w_in_hs;
  logic [3:0]       w_onehot;

  assign w_onehot   = 4'b0001 << r_cur_sel;
  assign w_out_hs   = (r_state != IDLE) & dout_ready[r_cur_sel];
  assign din_ready  = (r_state == IDLE) | ((r_state == SEND) & w_out_hs);
  assign w_in_hs    = din_valid & din_ready;
  assign dout       = r_dout;
  assign dout_valid = (r_state != IDLE) ? w_onehot : 4'b0000;
  assign active_sel = r_cur_sel;
  assign switching  = (r_state == MUTE);

  always_comb begin
    w_state_nxt   = r_state;
    w_cur_sel_nxt = r_cur_sel;
    w_pend_nxt    = r_pend;
    w_dout_nxt    = r_dout;
    w_held_nxt    = r_held;
    w_cnt_nxt     = r_cnt;
    unique case (r_state)
      IDLE, SEND: begin
        if (w_out_hs)
          w_state_nxt = IDLE;
        if (w_in_hs) begin
          if (s == r_cur_sel) begin
            w_dout_nxt  = din;
            w_state_nxt = SEND;
          end else begin
            w_held_nxt = din;
            w_pend_nxt = s;
            if (MUTE_LEN > 0) begin
              w_dout_nxt  = '0;
              w_cnt_nxt   = CW'(MUTE_LEN);
              w_state_nxt = MUTE;
            end else begin
              w_cur_sel_nxt = s;
              w_dout_nxt    = din;
              w_state_nxt   = SEND;
            end
          end
        end
      end
      MUTE: begin
        if (w_out_hs) begin
          w_cnt_nxt = r_cnt - CW'(1);
          // last zero accepted: swap to the pending channel
          if (r_cnt == CW'(1)) begin
            w_cur_sel_nxt = r_pend;
            w_dout_nxt    = r_held;
            w_state_nxt   = SEND;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cur_sel <= 2'd0;
      r_pend    <= 2'd0;
      r_dout    <= '0;
      r_held    <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_sel <= w_cur_sel_nxt;
      r_pend    <= w_pend_nxt;
      r_dout    <= w_dout_nxt;
      r_held    <= w_held_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

endmodule
